// File: rtl/prml_viterbi_soft_if.sv
// Sample/decision bus of the soft 1-D PRML Viterbi detector.
// The master drives samples and the counter clear; the slave returns decoded bits.
interface prml_viterbi_soft_if #(
  parameter int IN_W  = 6,
  parameter int CNT_W = 16
);
  logic                   in_valid;
  logic signed [IN_W-1:0] in_sample;
  logic                   clear_cnt;
  logic                   out_valid;
  logic                   out;
  logic                   error;
  logic [CNT_W-1:0]       err_count;

  modport master (
    output in_valid, in_sample, clear_cnt,
    input  out_valid, out, error, err_count
  );

  modport slave (
    input  in_valid, in_sample, clear_cnt,
    output out_valid, out, error, err_count
  );
endinterface

// File: rtl/prml_viterbi_soft.sv
// Two-state soft-decision Viterbi detector for the 1-D (dicode) channel with
// normalized saturating path metrics and register-exchange survivors.
module prml_viterbi_soft #(
  parameter int IN_W     = 6,
  parameter int AMP      = 16,
  parameter int PM_W     = 10,
  parameter int TB_DEPTH = 16,
  parameter int ERR_TH   = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  prml_viterbi_soft_if.slave  bus
);

  localparam int BM_W   = IN_W + 1;
  localparam int FILL_W = $clog2(TB_DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(TB_DEPTH);
  localparam logic [PM_W-1:0]   PM_MAX     = {PM_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [31:0]       ERR_TH_U   = 32'(ERR_TH);

  // |x - e| evaluated one bit wider than the sample so it never wraps
  function automatic logic [BM_W-1:0] branch_metric(
    input logic signed [IN_W-1:0] x,
    input logic signed [BM_W-1:0] e
  );
    logic signed [BM_W-1:0] xs;
    logic signed [BM_W-1:0] d;
    xs = {x[IN_W-1], x};
    d  = xs - e;
    return d[BM_W-1] ? (-d) : d;
  endfunction

  function automatic logic [PM_W-1:0] sat_add(
    input logic [PM_W-1:0] a,
    input logic [BM_W-1:0] b
  );
    logic [PM_W:0] sum;
    sum = {1'b0, a} + (PM_W+1)'(b);
    return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
  endfunction

  logic [1:0][PM_W-1:0]     pm_reg;
  logic [1:0][TB_DEPTH-1:0] surv_reg;
  logic [1:0][BM_W-1:0]     lastbm_reg;
  logic [FILL_W-1:0]        fill_reg;
  logic                     best_reg;
  logic                     out_valid_reg;
  logic [CNT_W-1:0]         err_count_reg;

  logic [1:0][PM_W-1:0]     acs_pm;
  logic [1:0][BM_W-1:0]     acs_bm;
  logic [1:0][TB_DEPTH-1:0] acs_surv;
  logic [1:0][PM_W-1:0]     pm_next;
  logic [PM_W-1:0]          pm_min;
  logic                     best_next;
  logic [FILL_W-1:0]        fill_next;
  logic                     error_now;

  // One ACS unit per destination state gi (gi is also the newest survivor bit)
  for (genvar gi = 0; gi < 2; gi++) begin : g_acs
    localparam logic signed [BM_W-1:0] EXP_FROM0 = (gi == 1) ? BM_W'(AMP)  : '0;
    localparam logic signed [BM_W-1:0] EXP_FROM1 = (gi == 0) ? BM_W'(-AMP) : '0;
    localparam logic                   NEW_BIT   = (gi == 1) ? 1'b1 : 1'b0;

    logic [BM_W-1:0]     bm0;
    logic [BM_W-1:0]     bm1;
    logic [PM_W-1:0]     cand0;
    logic [PM_W-1:0]     cand1;
    logic                take1;
    logic [TB_DEPTH-1:0] chosen;

    assign bm0    = branch_metric(bus.in_sample, EXP_FROM0);
    assign bm1    = branch_metric(bus.in_sample, EXP_FROM1);
    assign cand0  = sat_add(pm_reg[0], bm0);
    assign cand1  = sat_add(pm_reg[1], bm1);
    // strict compare: ties resolve toward predecessor state 0
    assign take1  = (cand1 < cand0);
    assign chosen = take1 ? surv_reg[1] : surv_reg[0];

    assign acs_pm[gi]   = take1 ? cand1 : cand0;
    assign acs_bm[gi]   = take1 ? bm1 : bm0;
    assign acs_surv[gi] = {chosen[TB_DEPTH-2:0], NEW_BIT};
  end

  always_comb begin
    best_next  = (acs_pm[1] < acs_pm[0]);
    pm_min     = best_next ? acs_pm[1] : acs_pm[0];
    pm_next[0] = acs_pm[0] - pm_min;
    pm_next[1] = acs_pm[1] - pm_min;
    fill_next  = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pm_reg[0]     <= '0;
      pm_reg[1]     <= PM_MAX;
      surv_reg      <= '0;
      lastbm_reg    <= '0;
      fill_reg      <= '0;
      best_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      if (bus.in_valid) begin
        pm_reg        <= pm_next;
        surv_reg      <= acs_surv;
        lastbm_reg    <= acs_bm;
        fill_reg      <= fill_next;
        best_reg      <= best_next;
        out_valid_reg <= (fill_next == FILL_FULL);
      end
    end
  end

  // Outputs decode straight from held state, so they freeze while in_valid is low
  assign error_now = (32'(lastbm_reg[best_reg]) > ERR_TH_U);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_count_reg <= '0;
    end else if (bus.clear_cnt) begin
      err_count_reg <= '0;
    end else if (out_valid_reg && error_now && (err_count_reg != CNT_MAX)) begin
      err_count_reg <= err_count_reg + 1'b1;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out       = surv_reg[best_reg][TB_DEPTH-1];
  assign bus.error     = error_now;
  assign bus.err_count = err_count_reg;

endmodule

// File: tb/tb_prml_viterbi_soft.sv
// Self-checking bench for prml_viterbi_soft: table vectors plus a reference
// model feeding an expected-output queue that is drained on every out_valid.
module tb_prml_viterbi_soft;
  localparam int IN_W     = 6;
  localparam int AMP      = 16;
  localparam int PM_W     = 10;
  localparam int TB_DEPTH = 16;
  localparam int ERR_TH   = 8;
  localparam int CNT_W    = 16;
  localparam int PM_MAX   = (1 << PM_W) - 1;
  localparam int NVEC     = 24;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  prml_viterbi_soft_if #(.IN_W(IN_W), .CNT_W(CNT_W)) bus ();
  prml_viterbi_soft_if #(.IN_W(IN_W), .CNT_W(4))     bus4 ();

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_sample = bus.in_sample;
  assign bus4.clear_cnt = bus.clear_cnt;

  prml_viterbi_soft #(.IN_W(IN_W), .AMP(AMP), .PM_W(PM_W), .TB_DEPTH(TB_DEPTH),
                      .ERR_TH(ERR_TH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .bus(bus));

  prml_viterbi_soft #(.IN_W(IN_W), .AMP(AMP), .PM_W(PM_W), .TB_DEPTH(TB_DEPTH),
                      .ERR_TH(ERR_TH), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4));

  typedef struct {
    int sample;
    bit v;
    bit o;
    bit e;
  } vec_t;

  vec_t       tbl [NVEC];
  logic [1:0] sbq [$];
  int         checks   = 0;
  int         failures = 0;
  logic       acc_prev = 1'b0;
  logic       prev_out = 1'b0;
  logic       prev_err = 1'b0;

  int          m_pm [2];
  logic [63:0] m_surv [2];
  int          m_lbm [2];
  int          m_fill;
  int          m_cnt;
  int          m_cnt4;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pm[0] = 0;  m_pm[1] = PM_MAX;
    m_surv[0] = '0; m_surv[1] = '0;
    m_lbm[0] = 0; m_lbm[1] = 0;
    m_fill = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  task automatic model_step(input int x, output bit v, output bit o, output bit e);
    int npm [2];
    int nbm [2];
    logic [63:0] ns [2];
    int c [2];
    int bmv [2];
    int ex;
    int mn;
    int b;
    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < 2; p++) begin
        ex = (p == s) ? 0 : ((s == 1) ? AMP : -AMP);
        bmv[p] = x - ex;
        if (bmv[p] < 0) bmv[p] = -bmv[p];
        c[p] = m_pm[p] + bmv[p];
        if (c[p] > PM_MAX) c[p] = PM_MAX;
      end
      if (c[1] < c[0]) begin
        npm[s] = c[1]; nbm[s] = bmv[1]; ns[s] = (m_surv[1] << 1) | 64'(s);
      end else begin
        npm[s] = c[0]; nbm[s] = bmv[0]; ns[s] = (m_surv[0] << 1) | 64'(s);
      end
    end
    mn = (npm[0] < npm[1]) ? npm[0] : npm[1];
    for (int s = 0; s < 2; s++) begin
      m_pm[s] = npm[s] - mn;
      m_surv[s] = ns[s];
      m_lbm[s] = nbm[s];
    end
    b = (m_pm[1] < m_pm[0]) ? 1 : 0;
    if (m_fill < TB_DEPTH) m_fill++;
    v = (m_fill == TB_DEPTH);
    o = m_surv[b][TB_DEPTH-1];
    e = (m_lbm[b] > ERR_TH);
    if (v && e) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  task automatic drive(input int x);
    bus.in_sample = IN_W'(x);
    bus.in_valid  = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_model(input int x);
    bit v, o, e;
    model_step(x, v, o, e);
    if (v) sbq.push_back({o, e});
    drive(x);
  endtask

  task automatic run_table(input int max_gap, input int noise_idx, input int noise_val);
    bit v, o, e;
    int x;
    for (int i = 0; i < NVEC; i++) begin
      x = (i == noise_idx) ? noise_val : tbl[i].sample;
      model_step(x, v, o, e);
      // decoded bits always come from the table; the flag from the model when noisy
      if (tbl[i].v) sbq.push_back({tbl[i].o, (noise_idx >= 0) ? e : tbl[i].e});
      drive(x);
      if (max_gap > 0) idle($urandom_range(max_gap));
    end
  endtask

  task automatic apply_reset(input string tag);
    bus.in_valid  = 1'b0;
    bus.clear_cnt = 1'b0;
    reset = 1'b0;
    #2;
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out"},       bus.out, 0);
    chk({tag, "_error"},     bus.error, 0);
    chk({tag, "_err_count"}, bus.err_count, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    sbq.delete();
  endtask

  task automatic end_test(input string tag);
    idle(4);
    chk({tag, "_sb_empty"}, sbq.size(), 0);
    chk({tag, "_err_count"}, bus.err_count, m_cnt);
    chk({tag, "_err_count4"}, bus4.err_count, m_cnt4);
  endtask

  always @(posedge clock) acc_prev <= bus.in_valid;

  always @(negedge clock) begin
    logic [1:0] ex;
    if (!reset) begin
      prev_out = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (!acc_prev) begin
        chk("hold_out", bus.out, prev_out);
        chk("hold_err", bus.error, prev_err);
      end
      if (bus.out_valid) begin
        chk("valid_after_sample", acc_prev, 1);
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=1 expected=0 at %0t", $time);
        end else begin
          ex = sbq.pop_front();
          chk("out_bit", bus.out, ex[1]);
          chk("err_flag", bus.error, ex[0]);
        end
        $display("out t=%0t bit=%0b err=%0b cnt=%0d", $time, bus.out, bus.error, bus.err_count);
      end
      prev_out = bus.out;
      prev_err = bus.error;
    end
  end

  initial begin
    int nrz [5]  = '{1, 0, 1, 1, 0};
    int smp [5]  = '{16, -16, 16, 0, -16};
    for (int i = 0; i < NVEC; i++) begin
      tbl[i].sample = (i < 5) ? smp[i] : 0;
      tbl[i].v      = (i >= TB_DEPTH - 1);
      tbl[i].o      = (i >= TB_DEPTH - 1 && i - (TB_DEPTH - 1) < 5) ? nrz[i - (TB_DEPTH - 1)][0] : 1'b0;
      tbl[i].e      = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.clear_cnt = 1'b0;
    #1;
    apply_reset("reset");

    run_table(0, -1, 0);
    end_test("noiseless");
    chk("noiseless_cnt_zero", bus.err_count, 0);

    apply_reset("rst2");
    run_table(0, 1, -6);
    end_test("noise");

    apply_reset("rst3");
    run_table(3, -1, 0);
    end_test("gapped");

    apply_reset("rst4");
    for (int i = 0; i < 40; i++) begin
      bit v, o, e;
      model_step(0, v, o, e);
      if (v) sbq.push_back(2'b00);
      drive(0);
    end
    end_test("zeros");

    apply_reset("rst5");
    for (int i = 0; i < 10; i++) drive(tbl[i].sample);
    apply_reset("midrst");
    run_table(0, -1, 0);
    end_test("replay");

    apply_reset("rst6");
    for (int i = 0; i < 20; i++) send_model(0);
    send_model(31);
    for (int i = 0; i < 20; i++) send_model(0);
    end_test("gross");
    chk("gross_one_error", bus.err_count, 1);

    for (int i = 0; i < 40; i++) send_model(31);
    end_test("saturate");
    chk("sat_cnt4_holds", bus4.err_count, 15);

    send_model(31);
    chk("clr_setup", bus.out_valid & bus.error, 1);
    bus.clear_cnt = 1'b1;
    @(posedge clock);
    #1;
    bus.clear_cnt = 1'b0;
    m_cnt  = 0;
    m_cnt4 = 0;
    chk("clr_priority", bus.err_count, 0);
    chk("clr_priority4", bus4.err_count, 0);
    end_test("clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
